down_count_monitor: RTL

Downstream consumer of the 3-bit ripple down-counter output q. It synchronises and deglitches q into the clk domain and checks that every settled change is a decrement by one, modulo 2^WIDTH. It also reports wrap events (000->111), keeps a wrap tally and flags skips and stalls. Its outputs feed status logic and the bench scoreboard.

---
 rtl/down_count_monitor_pkg.sv | 22 ++
 rtl/sync_settle_filter.sv | 52 +++++
 rtl/down_count_monitor.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/down_count_monitor_pkg.sv
// -----------------------------------------------------------------------------
// down_count_monitor_pkg
// Shared types and default constants for the ripple down-counter monitor and
// its synchroniser/settle filter.
//   mon_state_t     : monitor FSM states (SEED, TRACK, FAULT)
//   COUNT_W         : default width of the monitored count value
//   STALL_LIMIT_DEF : default idle-cycle limit before a stall is flagged
//   WRAP_CNT_W_DEF  : default width of the saturating wrap counter
// -----------------------------------------------------------------------------
package down_count_monitor_pkg;

    typedef enum logic [1:0] {
        SEED  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } mon_state_t;

    localparam int COUNT_W         = 3;
    localparam int STALL_LIMIT_DEF = 16;
    localparam int WRAP_CNT_W_DEF  = 8;

endpackage

// File: rtl/sync_settle_filter.sv
// -----------------------------------------------------------------------------
// sync_settle_filter
// Brings an asynchronous, possibly glitching multi-bit tap (e.g. a ripple
// counter output) into the clk domain with a two-flop synchroniser and marks
// the synchronised value as settled when two consecutive samples agree.
//   clk         in   clock
//   reset       in   synchronous active-low reset
//   d_in        in   raw asynchronous value
//   settled_val out  current synchronised sample
//   settled     out  settled_val equals the previous synchronised sample
// -----------------------------------------------------------------------------
module sync_settle_filter
    import down_count_monitor_pkg::*;
#(
    parameter int WIDTH = COUNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] settled_val,
    output logic             settled
);

    logic [WIDTH-1:0] q_p0, q_p1, q_p2;
    logic             vld_p0, vld_p1, vld_p2;

    // The vld_pN chain keeps the all-zero reset contents of the pipeline from
    // being mistaken for a settled value of 0 right after reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            q_p0   <= '0;
            q_p1   <= '0;
            q_p2   <= '0;
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            // p0/p1: two-flop synchroniser
            q_p0   <= d_in;
            q_p1   <= q_p0;
            // p2: previous synchronised sample for the settle compare
            q_p2   <= q_p1;
            vld_p0 <= 1'b1;
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;
        end
    end

    assign settled_val = q_p1;
    assign settled     = vld_p2 && (q_p1 == q_p2);

endmodule

// File: rtl/down_count_monitor.sv
// -----------------------------------------------------------------------------
// down_count_monitor
// Watches the output of a ripple down-counter, accepts only settled values and
// checks that each settled change is a decrement by one (mod 2^WIDTH).
// Reports wraps (0 -> all-ones), keeps a saturating wrap tally and flags
// skips and stalls with sticky error bits.
//   clk         in   clock, all state on rising edge
//   reset       in   synchronous active-low reset
//   q_in        in   raw counter value, asynchronous to clk
//   clr_err     in   single-cycle request: clear errors and reseed
//   valid       out  cur_value holds a settled, seeded value
//   cur_value   out  last accepted settled count
//   wrap_pulse  out  one-cycle pulse on an accepted wrap
//   wrap_count  out  saturating number of wraps
//   err_skip    out  sticky: settled change was not a decrement by one
//   err_stall   out  sticky: STALL_LIMIT cycles without an accepted change
// -----------------------------------------------------------------------------
module down_count_monitor
    import down_count_monitor_pkg::*;
#(
    parameter int WIDTH       = COUNT_W,
    parameter int STALL_LIMIT = STALL_LIMIT_DEF,
    parameter int WRAP_CNT_W  = WRAP_CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WIDTH-1:0]      q_in,
    input  logic                  clr_err,
    output logic                  valid,
    output logic [WIDTH-1:0]      cur_value,
    output logic                  wrap_pulse,
    output logic [WRAP_CNT_W-1:0] wrap_count,
    output logic                  err_skip,
    output logic                  err_stall
);

    localparam int                 STALL_W    = $clog2(STALL_LIMIT + 1);
    localparam logic [STALL_W-1:0] STALL_MAX  = STALL_W'(STALL_LIMIT);
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_LIMIT - 1);

    function automatic logic [WRAP_CNT_W-1:0] sat_inc(input logic [WRAP_CNT_W-1:0] v);
        return (&v) ? v : v + WRAP_CNT_W'(1);
    endfunction

    mon_state_t         state, state_nxt;
    logic [WIDTH-1:0]   settled_val;
    logic               settled;
    logic [WIDTH-1:0]   exp_val;
    logic               new_val;
    logic               step_ok;
    logic               skip_evt;
    logic               stall_evt;
    logic               err_evt;
    logic [STALL_W-1:0] stall_cnt;

    sync_settle_filter #(
        .WIDTH(WIDTH)
    ) u_filter (
        .clk        (clk),
        .reset      (reset),
        .d_in       (q_in),
        .settled_val(settled_val),
        .settled    (settled)
    );

    // Decision stage: classify the settled sample against cur_value
    assign exp_val   = cur_value - WIDTH'(1);
    assign new_val   = settled && (settled_val != cur_value);
    assign step_ok   = (settled_val == exp_val);
    assign skip_evt  = (state == TRACK) && new_val && !step_ok;
    assign stall_evt = (state == TRACK) && !new_val && (stall_cnt == STALL_LAST);
    assign err_evt   = skip_evt || stall_evt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= SEED;
        end else begin
            state <= state_nxt;
        end
    end

    // An error raised in the same cycle as clr_err takes precedence over it.
    always_comb begin
        state_nxt = state;
        case (state)
            SEED:    if (settled) state_nxt = TRACK;
            TRACK:   if (skip_evt) state_nxt = FAULT;
            FAULT:   state_nxt = FAULT;
            default: state_nxt = SEED;
        endcase
        if (clr_err && !err_evt) begin
            state_nxt = SEED;
        end
    end

    always_comb begin
        valid = (state != SEED);
    end

    // Update stage: accepted value, wrap tally, sticky errors, stall timer
    always_ff @(posedge clk) begin
        if (!reset) begin
            cur_value  <= '0;
            wrap_pulse <= 1'b0;
            wrap_count <= '0;
            err_skip   <= 1'b0;
            err_stall  <= 1'b0;
            stall_cnt  <= '0;
        end else begin
            wrap_pulse <= 1'b0;
            if (clr_err) begin
                err_skip  <= 1'b0;
                err_stall <= 1'b0;
                stall_cnt <= '0;
            end
            case (state)
                SEED: begin
                    if (settled) begin
                        cur_value <= settled_val;
                        stall_cnt <= '0;
                    end
                end
                TRACK: begin
                    if (new_val) begin
                        cur_value <= settled_val;
                        if (step_ok) begin
                            stall_cnt <= '0;
                            if (cur_value == '0) begin
                                wrap_pulse <= 1'b1;
                                wrap_count <= sat_inc(wrap_count);
                            end
                        end else begin
                            err_skip <= 1'b1;
                        end
                    end else if (stall_cnt == STALL_LAST) begin
                        // Counter parks at the limit so the flag fires once.
                        err_stall <= 1'b1;
                        stall_cnt <= STALL_MAX;
                    end else if (!clr_err && (stall_cnt < STALL_LAST)) begin
                        stall_cnt <= stall_cnt + STALL_W'(1);
                    end
                end
                FAULT: begin
                    if (new_val) begin
                        cur_value <= settled_val;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
